step_scheduler: RTL and testbench
=================================

STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 Parameter NUM_STEPS, default 8: steps per pattern loop.
REQ-002 Parameter CNT_W, default 20: width of the step-length and cycle counters.
REQ-003 Parameter MIN_STEP, default 16: smallest accepted step length, in cycles.
REQ-004 Port clk  in  1: single system clock (hz2m domain); all state updates on the rising edge.
REQ-005 Port rst  in  1: asynchronous, active-low reset; asserted when 0.
REQ-006 Port mode  in  2: 0 = edit, 1 = play, 2 = raw, 3 = reserved.
REQ-007 Port step_len  in  CNT_W: requested step length in clk cycles (tempo).
REQ-008 Port step_smpl  in  4: pattern voices for the step at step_idx, looked up combinationally by the pattern store.
REQ-009 Port raw_req  in  4: live pad requests, one bit per voice.
REQ-010 Port step_idx  out  3: current step index into the pattern store.
REQ-011 Port step_onehot  out  NUM_STEPS: one-hot copy of step_idx, for step LEDs; all zero when not playing.
REQ-012 Port step_tick  out  1: one-cycle pulse at each step boundary.
REQ-013 Port play_smpl  out  4: per-voice enables to the sample players (bit3 kick, bit2 clap, bit1 hihat, bit0 snare).

Function
REQ-014 The FSM SHALL have states IDLE, GATE and REST, with a cycle counter cnt (CNT_W bits).
REQ-015 Tempo latch: step_len SHALL be latched into len_q only on entry to play and at each step boundary.
- Clamp: len_q = max(step_len, MIN_STEP).
- Gate length: gate_q = len_q - (len_q >> 3), using integer truncation.
- A step_len change in mid-step SHALL NOT alter the step in progress.
REQ-016 IDLE: when mode == 1, go to GATE with cnt = 0, step_idx = 0, tempo latched, and no step_tick.
REQ-017 GATE: cnt increments each cycle; when cnt == gate_q-1, go to REST and continue counting.
REQ-018 REST boundary: when cnt == len_q-1:
- set cnt = 0;
- step_idx increments, wrapping NUM_STEPS-1 -> 0;
- step_tick = 1 for exactly that cycle;
- tempo is relatched;
- go to GATE.
REQ-019 Leaving play: in GATE or REST, mode != 1 SHALL return the FSM to IDLE on the next edge, with cnt = 0 and step_idx = 0. This takes priority over a coincident boundary.
REQ-020 play_smpl SHALL be registered, with one-cycle latency from its inputs:
- GATE: step_smpl | raw_req
- REST: raw_req
- IDLE with mode 2: raw_req
- IDLE with mode 0 or 3: 4'b0
REQ-021 REST SHALL force every pattern-driven voice low for len_q - gate_q (at least 2) cycles, so the same voice on consecutive steps retriggers.
REQ-022 step_onehot SHALL equal 1 << step_idx in GATE and REST, and 0 in IDLE.
REQ-023 All outputs SHALL be registered, and no combinational path SHALL run from inputs to outputs.

Reset
REQ-024 While rst == 0, the block SHALL be asynchronously forced to:
- state = IDLE, cnt = 0, len_q = MIN_STEP, gate_q = MIN_STEP - (MIN_STEP >> 3)
- step_idx = 0, step_onehot = 0, step_tick = 0, play_smpl = 0
REQ-025 A reset asserted mid-step SHALL abandon the step with no step_tick.
- After release, play SHALL restart at step 0 on the first edge at which mode == 1.

Verification
REQ-026 Scenario: step_len = 100, mode goes 0 -> 1, step_smpl = 4'b1000 -> play_smpl = 4'b1000 for 88 cycles, then 0 for 12 cycles; step_tick at cycle 100 of the step; step_idx = 1.
REQ-027 Scenario: run 8 steps with step_len = 100 -> step_idx sequence 0..7 then 0; exactly 8 step_tick pulses 100 cycles apart; step_onehot = 8'h80 during step 7.
REQ-028 Scenario: step_len changed from 100 to 200 at cycle 50 of step 2 -> step 2 still lasts 100 cycles; step 3 lasts 200 cycles with a gate of 175.
REQ-029 Scenario: step_len = 5 -> clamped to 16; gate = 14 cycles, rest = 2 cycles.
REQ-030 Scenario: mode = 2, raw_req = 4'b0101 -> play_smpl = 4'b0101 one cycle later. Then mode = 1 with raw_req = 4'b0001 during REST -> play_smpl = 4'b0001.
REQ-031 Scenario: rst pulsed low at cycle 40 of step 3 -> all outputs 0 immediately. After release with mode = 1, step_idx = 0, and the first step_tick occurs len_q cycles later.

Source files
------------

// File: rtl/step_scheduler_if.sv
// Control inputs and step/voice outputs of the step scheduler.
// The master drives mode, tempo and voice requests; the slave returns step position and voice enables.
interface step_scheduler_if #(
   parameter int NUM_STEPS = 8,
   parameter int CNT_W     = 20
);
   logic [1:0]           mode;
   logic [CNT_W-1:0]     step_len;
   logic [3:0]           step_smpl;
   logic [3:0]           raw_req;
   logic [2:0]           step_idx;
   logic [NUM_STEPS-1:0] step_onehot;
   logic                 step_tick;
   logic [3:0]           play_smpl;

   modport master (
      output mode, step_len, step_smpl, raw_req,
      input  step_idx, step_onehot, step_tick, play_smpl
   );

   modport slave (
      input  mode, step_len, step_smpl, raw_req,
      output step_idx, step_onehot, step_tick, play_smpl
   );
endinterface

// File: rtl/step_scheduler.sv
// Drum step sequencer: plays pattern voices for a gate, then forces a rest so repeated voices retrigger.
// Every output is registered (one-cycle latency from inputs); free-running, no backpressure.
module step_scheduler #(
   parameter int NUM_STEPS = 8,
   parameter int CNT_W     = 20,
   parameter int MIN_STEP  = 16
) (
   input  logic           clk,
   input  logic           rst,
   step_scheduler_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GATE = 2'd1,
      REST = 2'd2
   } state_t;

   localparam logic [1:0]       MODE_PLAY = 2'd1;
   localparam logic [1:0]       MODE_RAW  = 2'd2;
   localparam logic [CNT_W-1:0] MIN_LEN   = CNT_W'(MIN_STEP);
   localparam logic [CNT_W-1:0] MIN_GATE  = MIN_LEN - (MIN_LEN >> 3);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [2:0]       LAST_IDX  = 3'(NUM_STEPS - 1);
   localparam logic [NUM_STEPS-1:0] ONEHOT_ZERO = '0;
   localparam logic [NUM_STEPS-1:0] ONEHOT_BIT0 = NUM_STEPS'(1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     len_q, len_d;
   logic [CNT_W-1:0]     gate_q, gate_d;
   logic [2:0]           idx_q, idx_d;
   logic [NUM_STEPS-1:0] onehot_q, onehot_d;
   logic                 tick_q, tick_d;
   logic [3:0]           play_q, play_d;

   logic [CNT_W-1:0]     lat_len;
   logic [CNT_W-1:0]     lat_gate;
   logic                 playing;

   // Tempo candidate, only taken at play entry and step boundaries.
   always_comb begin
      lat_len  = (bus.step_len < MIN_LEN) ? MIN_LEN : bus.step_len;
      lat_gate = lat_len - (lat_len >> 3);
      playing  = (bus.mode == MODE_PLAY);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         len_q    <= MIN_LEN;
         gate_q   <= MIN_GATE;
         idx_q    <= '0;
         onehot_q <= '0;
         tick_q   <= 1'b0;
         play_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         gate_q   <= gate_d;
         idx_q    <= idx_d;
         onehot_q <= onehot_d;
         tick_q   <= tick_d;
         play_q   <= play_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      gate_d  = gate_q;
      idx_d   = idx_q;
      tick_d  = 1'b0;
      play_d  = '0;

      case (state_q)
         IDLE: begin
            play_d = (bus.mode == MODE_RAW) ? bus.raw_req : 4'b0000;
            if (playing) begin
               state_d = GATE;
               cnt_d   = '0;
               idx_d   = '0;
               len_d   = lat_len;
               gate_d  = lat_gate;
            end
         end

         GATE: begin
            play_d = bus.step_smpl | bus.raw_req;
            if (!playing) begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == gate_q - CNT_ONE) begin
                  state_d = REST;
               end
            end
         end

         REST: begin
            // Pattern voices are held off here so back-to-back hits re-trigger.
            play_d = bus.raw_req;
            if (!playing) begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == len_q - CNT_ONE) begin
               state_d = GATE;
               cnt_d   = '0;
               idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
               tick_d  = 1'b1;
               len_d   = lat_len;
               gate_d  = lat_gate;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      onehot_d = (state_d == IDLE) ? ONEHOT_ZERO : (ONEHOT_BIT0 << idx_d);
   end

   assign bus.step_idx    = idx_q;
   assign bus.step_onehot = onehot_q;
   assign bus.step_tick   = tick_q;
   assign bus.play_smpl   = play_q;
endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: idle-mode vector table, hand-written tempo/reset sequences, random run vs model.
module tb_step_scheduler;
   localparam int NS = 8;
   localparam int CW = 20;
   localparam int MS = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   step_scheduler_if #(.NUM_STEPS(NS), .CNT_W(CW)) bus ();

   step_scheduler #(.NUM_STEPS(NS), .CNT_W(CW), .MIN_STEP(MS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a step is a span of len cycles, the first gate of which play the pattern.
   bit m_play;
   int m_pos, m_idx, m_len, m_gate;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] raw;
      logic [3:0] smpl;
      logic [3:0] exp_play;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic watch(input int n, input logic [3:0] pat,
                        output int npat, output int first_tick, output int ntick);
      npat = 0; first_tick = 0; ntick = 0;
      for (int k = 1; k <= n; k++) begin
         cyc();
         if (bus.play_smpl == pat) npat++;
         if (bus.step_tick) begin
            ntick++;
            if (first_tick == 0) first_tick = k;
         end
      end
   endtask

   task automatic go_idle();
      bus.mode = 2'd0;
      cyc();
   endtask

   task automatic m_reset();
      m_play = 0; m_pos = 0; m_idx = 0; m_len = MS; m_gate = MS - MS / 8;
   endtask

   task automatic m_latch(input int sl);
      m_len  = (sl < MS) ? MS : sl;
      m_gate = m_len - m_len / 8;
   endtask

   task automatic m_edge(input int mode, input int sl, input int smpl, input int raw,
                         output int ep, output int et);
      et = 0;
      if (m_play) ep = (m_pos < m_gate) ? (smpl | raw) : raw;
      else        ep = (mode == 2) ? raw : 0;
      if (!m_play) begin
         if (mode == 1) begin
            m_play = 1; m_pos = 0; m_idx = 0; m_latch(sl);
         end
      end else if (mode != 1) begin
         m_play = 0; m_pos = 0; m_idx = 0;
      end else if (m_pos == m_len - 1) begin
         m_pos = 0; m_idx = (m_idx + 1) % NS; et = 1; m_latch(sl);
      end else begin
         m_pos++;
      end
   endtask

   initial begin
      vec_t vecs[6];
      int npat, ft, nt, tot;
      int ep, et;

      vecs[0] = '{2'd2, 4'b0101, 4'b1000, 4'b0101};
      vecs[1] = '{2'd0, 4'b1111, 4'b1111, 4'b0000};
      vecs[2] = '{2'd3, 4'b1010, 4'b0110, 4'b0000};
      vecs[3] = '{2'd2, 4'b1000, 4'b0001, 4'b1000};
      vecs[4] = '{2'd2, 4'b0000, 4'b1111, 4'b0000};
      vecs[5] = '{2'd2, 4'b1111, 4'b0000, 4'b1111};

      bus.mode = 2'd0; bus.step_len = CW'(100); bus.step_smpl = 4'b0; bus.raw_req = 4'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("reset_play", bus.play_smpl, 0);
      chk("reset_idx", bus.step_idx, 0);
      chk("reset_onehot", bus.step_onehot, 0);
      chk("reset_tick", bus.step_tick, 0);
      cyc();
      rst = 1'b1;

      // Idle-mode voice routing
      for (int i = 0; i < 6; i++) begin
         bus.mode = vecs[i].mode; bus.raw_req = vecs[i].raw; bus.step_smpl = vecs[i].smpl;
         cyc();
         chk($sformatf("idle_play[%0d]", i), bus.play_smpl, vecs[i].exp_play);
         chk($sformatf("idle_onehot[%0d]", i), bus.step_onehot, 0);
         chk($sformatf("idle_tick[%0d]", i), bus.step_tick, 0);
      end

      // First step at 100 cycles, then a full loop of 8 steps
      go_idle();
      bus.step_len = CW'(100); bus.step_smpl = 4'b1000; bus.raw_req = 4'b0; bus.mode = 2'd1;
      cyc();
      chk("entry_idx", bus.step_idx, 0);
      chk("entry_onehot", bus.step_onehot, 1);
      chk("entry_tick", bus.step_tick, 0);
      watch(88, 4'b1000, npat, ft, nt);
      chk("s0_gate_cycles", npat, 88);
      chk("s0_gate_ticks", nt, 0);
      watch(12, 4'b0000, npat, ft, nt);
      chk("s0_rest_cycles", npat, 12);
      chk("s0_tick_pos", ft, 12);
      chk("s0_idx_after", bus.step_idx, 1);
      tot = nt;
      for (int s = 1; s < NS; s++) begin
         watch(50, 4'b1000, npat, ft, nt);
         tot += nt;
         chk($sformatf("loop_onehot[%0d]", s), bus.step_onehot, 1 << s);
         watch(50, 4'b1000, npat, ft, nt);
         tot += nt;
         chk($sformatf("loop_tick_pos[%0d]", s), ft, 50);
         chk($sformatf("loop_idx[%0d]", s), bus.step_idx, (s + 1) % NS);
      end
      chk("loop_tick_total", tot, 8);

      // Tempo change mid-step only takes effect at the next boundary
      go_idle();
      bus.step_len = CW'(100); bus.mode = 2'd1;
      cyc();
      watch(100, 4'b1000, npat, ft, nt);
      watch(100, 4'b1000, npat, ft, nt);
      chk("tc_s1_tick", ft, 100);
      watch(50, 4'b1000, npat, ft, nt);
      bus.step_len = CW'(200);
      watch(50, 4'b1000, npat, ft, nt);
      chk("tc_s2_len", ft, 50);
      watch(175, 4'b1000, npat, ft, nt);
      chk("tc_s3_gate", npat, 175);
      chk("tc_s3_gate_ticks", nt, 0);
      watch(25, 4'b0000, npat, ft, nt);
      chk("tc_s3_rest", npat, 25);
      chk("tc_s3_tick", ft, 25);

      // Short step clamps to the minimum length
      go_idle();
      bus.step_len = CW'(5); bus.mode = 2'd1;
      cyc();
      watch(14, 4'b1000, npat, ft, nt);
      chk("clamp_gate", npat, 14);
      chk("clamp_gate_ticks", nt, 0);
      watch(2, 4'b0000, npat, ft, nt);
      chk("clamp_rest", npat, 2);
      chk("clamp_tick", ft, 2);

      // Raw pads in raw mode and through the rest window
      go_idle();
      bus.mode = 2'd2; bus.raw_req = 4'b0101;
      cyc();
      chk("raw_mode_play", bus.play_smpl, 4'b0101);
      bus.step_len = CW'(16); bus.step_smpl = 4'b1000; bus.raw_req = 4'b0001; bus.mode = 2'd1;
      cyc();
      watch(14, 4'b1001, npat, ft, nt);
      chk("raw_gate_mix", npat, 14);
      watch(2, 4'b0001, npat, ft, nt);
      chk("raw_rest_pads", npat, 2);

      // Reset mid-step abandons the step; play restarts at step 0
      go_idle();
      bus.step_len = CW'(100); bus.raw_req = 4'b0; bus.mode = 2'd1;
      cyc();
      watch(340, 4'b1000, npat, ft, nt);
      chk("rst_pre_idx", bus.step_idx, 3);
      rst = 1'b0;
      #1;
      chk("rst_async_play", bus.play_smpl, 0);
      chk("rst_async_idx", bus.step_idx, 0);
      chk("rst_async_onehot", bus.step_onehot, 0);
      chk("rst_async_tick", bus.step_tick, 0);
      cyc();
      chk("rst_hold_onehot", bus.step_onehot, 0);
      rst = 1'b1;
      cyc();
      chk("rst_restart_idx", bus.step_idx, 0);
      chk("rst_restart_onehot", bus.step_onehot, 1);
      watch(100, 4'b1000, npat, ft, nt);
      chk("rst_first_tick", ft, 100);
      chk("rst_tick_count", nt, 1);

      // Random run against the model
      rst = 1'b0;
      cyc();
      m_reset();
      rst = 1'b1;
      bus.mode = 2'd1; bus.step_len = CW'(20);
      for (int i = 0; i < 4000; i++) begin
         int r;
         if ($urandom_range(0, 79) == 0) begin
            r = $urandom_range(0, 5);
            bus.mode = (r >= 3) ? 2'd1 : 2'(r);
         end
         if ($urandom_range(0, 14) == 0) bus.step_len = CW'($urandom_range(0, 40));
         bus.step_smpl = 4'($urandom_range(0, 15));
         bus.raw_req   = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         cyc();
         if (!rst) begin
            m_reset(); ep = 0; et = 0;
         end else begin
            m_edge(int'(bus.mode), int'(bus.step_len), int'(bus.step_smpl), int'(bus.raw_req), ep, et);
         end
         chk("rnd_play", bus.play_smpl, ep);
         chk("rnd_tick", bus.step_tick, et);
         chk("rnd_idx", bus.step_idx, m_idx);
         chk("rnd_onehot", bus.step_onehot, m_play ? (1 << m_idx) : 0);
      end
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
